timing_control: RTL and testbench
=================================

TIMING_CONTROL -- requirements
Module: timing_control

Interface
REQ-001 SHALL have parameter T_WIDTH, default 3: width of the timing count t.
REQ-002 SHALL have one clock; reset is asynchronous and active-high.
REQ-003 CLK  in  1  rising-edge clock.
REQ-004 RST  in  1  asynchronous, active-high reset.
REQ-005 START  in  1  one-cycle request to set RUN while halted.
REQ-006 IR  in  16  instruction register contents: IR[15] = I, IR[14:12] = opcode.
REQ-007 DR_ZERO  in  1  datapath flag: DR equals 0 after increment.
REQ-008 t  out  T_WIDTH  timing count T0..T6, driven to MEMORY.
REQ-009 D  out  8  registered one-hot opcode decode D0..D7.
REQ-010 I  out  1  registered indirect bit.
REQ-011 RUN  out  1  run flip-flop S.
REQ-012 Strobes, out, 1 bit each: MEM_RD, MEM_WR, AR_LD_PC, AR_LD_IR, AR_LD_MEM, AR_INR, IR_LD, PC_INR, PC_LD_AR, DR_LD, DR_INR, RR_EXEC.
REQ-013 AC_OP  out  2  accumulator operation: 00 none, 01 AND, 10 ADD, 11 LOAD.

Function
REQ-014 All strobes and AC_OP SHALL be combinational decodes of the registered t, D, I, RUN and DR_ZERO; the datapath acts on the edge that closes the T-state.
REQ-015 When RUN=0, t SHALL hold 0 and every strobe SHALL be 0.
REQ-016 When RUN=0 and START=1, RUN SHALL be set on the next edge; T0 begins in the following cycle.
REQ-017 START while RUN=1 SHALL be ignored.
REQ-018 T0: assert AR_LD_PC.
REQ-019 T1: assert MEM_RD, IR_LD and PC_INR.
REQ-020 T2: assert AR_LD_IR; at the closing edge, latch D from IR[14:12] and I from IR[15].
REQ-021 T3 with D7=0, I=1: assert MEM_RD and AR_LD_MEM.
REQ-022 T3 with D7=0, I=0: no strobes.
REQ-023 T3 with D7=1: assert RR_EXEC and clear t to 0.
REQ-024 T3 with D7=1, I=0, IR[0]=1 (HLT): also clear RUN at the same edge.
REQ-025 T4 with D0, D1, D2 or D6: assert MEM_RD and DR_LD.
REQ-026 T4 with D3: assert MEM_WR and clear t.
REQ-027 T4 with D4: assert PC_LD_AR and clear t.
REQ-028 T4 with D5: assert MEM_WR and AR_INR.
REQ-029 T5: D0 sets AC_OP=01 and clears t; D1 sets 10 and clears t; D2 sets 11 and clears t.
REQ-030 T5 with D5: assert PC_LD_AR and clear t.
REQ-031 T5 with D6: assert DR_INR.
REQ-032 T6 with D6: assert MEM_WR, assert PC_INR iff DR_ZERO=1, and clear t.
REQ-033 In every other T-state, t SHALL increment by 1; t SHALL never exceed 6.
REQ-034 MEM_RD and MEM_WR SHALL never be asserted in the same cycle.
REQ-035 At most one AR_* strobe SHALL be asserted per cycle.

Reset
REQ-036 RST=1 SHALL asynchronously force t=0, D=0, I=0 and RUN=0; all strobes and AC_OP then read 0.
REQ-037 RST asserted mid-instruction SHALL abort it; no strobe SHALL fire after RST is asserted.
REQ-038 After RST is released, the block SHALL stay halted until START.

Structure
REQ-039 A shared package mano_pkg SHALL hold: opcode constants (AND=0 .. BSA=5, ISZ=6, RR/IO=7), the AC_OP encodings, and the T-state constants T0..T6.
REQ-040 The counter SHALL be a sub-module seq_counter (T_WIDTH bits; inputs CLR, INR; holds otherwise; async reset); timing_control instantiates it once.

Verification
REQ-041 Reset, START, IR=16'h2005 (LDA, direct): t runs 0..5 then 0; DR_LD at T4; AC_OP=11 at T5; no AR_LD_MEM.
REQ-042 IR=16'hB005 (STA, indirect): AR_LD_MEM at T3; MEM_WR at T4; t returns to 0 after T4.
REQ-043 IR=16'h6010 (ISZ) with DR_ZERO=1 at T6: MEM_WR and PC_INR both asserted at T6.
REQ-044 IR=16'h6010 (ISZ) with DR_ZERO=0 at T6: MEM_WR asserted, PC_INR not asserted.
REQ-045 IR=16'h7001 (HLT): RR_EXEC at T3; RUN=0 next cycle; t stays 0 and strobes stay 0 until a new START.
REQ-046 RST pulsed during T4 of IR=16'h5020 (BSA): t=0, RUN=0 and MEM_WR=0 immediately; idle until START.

Source files
------------

// File: rtl/mano_pkg.sv
// Shared constants for the basic-computer control unit: opcodes, AC operation codes,
// T-state numbers, run-state encoding and the bundle of datapath strobes.
package mano_pkg;

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_ADD  = 3'd1;
    localparam logic [2:0] OP_LDA  = 3'd2;
    localparam logic [2:0] OP_STA  = 3'd3;
    localparam logic [2:0] OP_BUN  = 3'd4;
    localparam logic [2:0] OP_BSA  = 3'd5;
    localparam logic [2:0] OP_ISZ  = 3'd6;
    localparam logic [2:0] OP_RRIO = 3'd7;

    typedef enum logic [1:0] {
        AC_NONE = 2'b00,
        AC_AND  = 2'b01,
        AC_ADD  = 2'b10,
        AC_LOAD = 2'b11
    } acOp_e;

    localparam logic [2:0] T0 = 3'd0;
    localparam logic [2:0] T1 = 3'd1;
    localparam logic [2:0] T2 = 3'd2;
    localparam logic [2:0] T3 = 3'd3;
    localparam logic [2:0] T4 = 3'd4;
    localparam logic [2:0] T5 = 3'd5;
    localparam logic [2:0] T6 = 3'd6;

    typedef enum logic {
        ST_HALT = 1'b0,
        ST_RUN  = 1'b1
    } runState_e;

    typedef struct packed {
        logic memRd;
        logic memWr;
        logic arLdPc;
        logic arLdIr;
        logic arLdMem;
        logic arInr;
        logic irLd;
        logic pcInr;
        logic pcLdAr;
        logic drLd;
        logic drInr;
        logic rrExec;
    } strobes_t;

    function automatic logic [7:0] decodeOp(input logic [2:0] op);
        decodeOp = 8'b0000_0001 << op;
    endfunction

endpackage

// File: rtl/timing_control_if.sv
// Handshake bundle between the control unit and the datapath/memory side.
interface timing_control_if #(parameter int T_WIDTH = 3);

    logic               start_i;
    logic [15:0]        ir_i;
    logic               drZero_i;
    logic [T_WIDTH-1:0] t_o;
    logic [7:0]         d_o;
    logic               i_o;
    logic               run_o;
    logic               memRd_o;
    logic               memWr_o;
    logic               arLdPc_o;
    logic               arLdIr_o;
    logic               arLdMem_o;
    logic               arInr_o;
    logic               irLd_o;
    logic               pcInr_o;
    logic               pcLdAr_o;
    logic               drLd_o;
    logic               drInr_o;
    logic               rrExec_o;
    logic [1:0]         acOp_o;

    modport master (
        output start_i, ir_i, drZero_i,
        input  t_o, d_o, i_o, run_o, memRd_o, memWr_o, arLdPc_o, arLdIr_o, arLdMem_o,
               arInr_o, irLd_o, pcInr_o, pcLdAr_o, drLd_o, drInr_o, rrExec_o, acOp_o
    );

    modport slave (
        input  start_i, ir_i, drZero_i,
        output t_o, d_o, i_o, run_o, memRd_o, memWr_o, arLdPc_o, arLdIr_o, arLdMem_o,
               arInr_o, irLd_o, pcInr_o, pcLdAr_o, drLd_o, drInr_o, rrExec_o, acOp_o
    );

endinterface

// File: rtl/seq_counter.sv
// Sequence counter for the T-states: synchronous clear wins over increment.
module seq_counter #(
    parameter int T_WIDTH = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr_i,
    input  logic               inr_i,
    output logic [T_WIDTH-1:0] count_o
);

    logic [T_WIDTH-1:0] countQ;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            countQ <= '0;
        end else if (clr_i) begin
            countQ <= '0;
        end else if (inr_i) begin
            countQ <= countQ + T_WIDTH'(1);
        end
    end

    assign count_o = countQ;

endmodule

// File: rtl/timing_control.sv
// Control unit: fetch/decode/execute sequencing of the basic computer, producing
// datapath strobes as combinational decodes of t, D, I, RUN and DR_ZERO.
module timing_control
    import mano_pkg::*;
#(
    parameter int T_WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    timing_control_if.slave  bus
);

    runState_e          stateQ, stateD;
    logic [7:0]         dQ, dD;
    logic               iQ, iD;
    logic [T_WIDTH-1:0] tQ;
    logic               clrT, inrT;
    strobes_t           strb;
    acOp_e              acOp;

    seq_counter #(.T_WIDTH(T_WIDTH)) uSeqCounter (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (clrT),
        .inr_i   (inrT),
        .count_o (tQ)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateQ <= ST_HALT;
            dQ     <= '0;
            iQ     <= 1'b0;
        end else begin
            stateQ <= stateD;
            dQ     <= dD;
            iQ     <= iD;
        end
    end

    // Every strobe is gated by RUN, so an async reset silences them in the same instant.
    always_comb begin
        stateD = stateQ;
        dD     = dQ;
        iD     = iQ;
        clrT   = 1'b0;
        strb   = '0;
        acOp   = AC_NONE;
        unique case (stateQ)
            ST_HALT: begin
                clrT = 1'b1;
                if (bus.start_i) stateD = ST_RUN;
            end
            ST_RUN: begin
                case (tQ)
                    T_WIDTH'(T0): strb.arLdPc = 1'b1;
                    T_WIDTH'(T1): begin
                        strb.memRd = 1'b1;
                        strb.irLd  = 1'b1;
                        strb.pcInr = 1'b1;
                    end
                    T_WIDTH'(T2): begin
                        strb.arLdIr = 1'b1;
                        dD          = decodeOp(bus.ir_i[14:12]);
                        iD          = bus.ir_i[15];
                    end
                    T_WIDTH'(T3): begin
                        if (dQ[OP_RRIO]) begin
                            strb.rrExec = 1'b1;
                            clrT        = 1'b1;
                            if (!iQ && bus.ir_i[0]) stateD = ST_HALT;
                        end else if (iQ) begin
                            strb.memRd   = 1'b1;
                            strb.arLdMem = 1'b1;
                        end
                    end
                    T_WIDTH'(T4): begin
                        if (dQ[OP_AND] || dQ[OP_ADD] || dQ[OP_LDA] || dQ[OP_ISZ]) begin
                            strb.memRd = 1'b1;
                            strb.drLd  = 1'b1;
                        end else if (dQ[OP_STA]) begin
                            strb.memWr = 1'b1;
                            clrT       = 1'b1;
                        end else if (dQ[OP_BUN]) begin
                            strb.pcLdAr = 1'b1;
                            clrT        = 1'b1;
                        end else if (dQ[OP_BSA]) begin
                            strb.memWr = 1'b1;
                            strb.arInr = 1'b1;
                        end else begin
                            clrT = 1'b1;
                        end
                    end
                    T_WIDTH'(T5): begin
                        if (dQ[OP_AND]) begin
                            acOp = AC_AND;
                            clrT = 1'b1;
                        end else if (dQ[OP_ADD]) begin
                            acOp = AC_ADD;
                            clrT = 1'b1;
                        end else if (dQ[OP_LDA]) begin
                            acOp = AC_LOAD;
                            clrT = 1'b1;
                        end else if (dQ[OP_BSA]) begin
                            strb.pcLdAr = 1'b1;
                            clrT        = 1'b1;
                        end else if (dQ[OP_ISZ]) begin
                            strb.drInr = 1'b1;
                        end else begin
                            clrT = 1'b1;
                        end
                    end
                    T_WIDTH'(T6): begin
                        if (dQ[OP_ISZ]) begin
                            strb.memWr = 1'b1;
                            strb.pcInr = bus.drZero_i;
                        end
                        clrT = 1'b1;
                    end
                    default: clrT = 1'b1;
                endcase
            end
            default: stateD = ST_HALT;
        endcase
    end

    assign inrT = (stateQ == ST_RUN) && !clrT;

    assign bus.t_o       = tQ;
    assign bus.d_o       = dQ;
    assign bus.i_o       = iQ;
    assign bus.run_o     = (stateQ == ST_RUN);
    assign bus.memRd_o   = strb.memRd;
    assign bus.memWr_o   = strb.memWr;
    assign bus.arLdPc_o  = strb.arLdPc;
    assign bus.arLdIr_o  = strb.arLdIr;
    assign bus.arLdMem_o = strb.arLdMem;
    assign bus.arInr_o   = strb.arInr;
    assign bus.irLd_o    = strb.irLd;
    assign bus.pcInr_o   = strb.pcInr;
    assign bus.pcLdAr_o  = strb.pcLdAr;
    assign bus.drLd_o    = strb.drLd;
    assign bus.drInr_o   = strb.drInr;
    assign bus.rrExec_o  = strb.rrExec;
    assign bus.acOp_o    = acOp;

endmodule

// File: tb/tb_timing_control.sv
// Random and directed instruction streams against a microprogram-table reference model.
module tb_timing_control;

    localparam logic [11:0] M_RD    = 12'h001;
    localparam logic [11:0] M_WR    = 12'h002;
    localparam logic [11:0] M_ARPC  = 12'h004;
    localparam logic [11:0] M_ARIR  = 12'h008;
    localparam logic [11:0] M_ARMEM = 12'h010;
    localparam logic [11:0] M_ARINR = 12'h020;
    localparam logic [11:0] M_IRLD  = 12'h040;
    localparam logic [11:0] M_PCINR = 12'h080;
    localparam logic [11:0] M_PCLD  = 12'h100;
    localparam logic [11:0] M_DRLD  = 12'h200;
    localparam logic [11:0] M_DRINR = 12'h400;
    localparam logic [11:0] M_RR    = 12'h800;

    typedef struct {
        int          t;
        logic [11:0] strb;
        logic [1:0]  acOp;
    } step_t;

    logic  clk = 1'b0;
    logic  rst;
    int    compareCount  = 0;
    int    mismatchCount = 0;
    step_t trace[$];

    timing_control_if #(.T_WIDTH(3)) bus ();

    timing_control #(.T_WIDTH(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", tag, $time, observed, expected);
        end
    endtask

    function automatic logic [11:0] getStrobes();
        return {bus.rrExec_o, bus.drInr_o, bus.drLd_o, bus.pcLdAr_o, bus.pcInr_o, bus.irLd_o,
                bus.arInr_o, bus.arLdMem_o, bus.arLdIr_o, bus.arLdPc_o, bus.memWr_o, bus.memRd_o};
    endfunction

    function automatic void pushStep(input logic [11:0] s, input logic [1:0] ac);
        step_t st;
        st.t    = trace.size();
        st.strb = s;
        st.acOp = ac;
        trace.push_back(st);
    endfunction

    // Reference: fixed fetch microprogram followed by a per-opcode execute table; t is the step index.
    function automatic bit buildTrace(input logic [15:0] ir, input bit drZ);
        int op  = int'(ir[14:12]);
        bit ind = ir[15];
        trace.delete();
        pushStep(M_ARPC, 2'b00);
        pushStep(M_RD | M_IRLD | M_PCINR, 2'b00);
        pushStep(M_ARIR, 2'b00);
        if (op == 7) begin
            pushStep(M_RR, 2'b00);
            return !ind && ir[0];
        end
        pushStep(ind ? (M_RD | M_ARMEM) : 12'h000, 2'b00);
        case (op)
            0, 1, 2: begin
                pushStep(M_RD | M_DRLD, 2'b00);
                pushStep(12'h000, (op == 0) ? 2'b01 : (op == 1) ? 2'b10 : 2'b11);
            end
            3: pushStep(M_WR, 2'b00);
            4: pushStep(M_PCLD, 2'b00);
            5: begin
                pushStep(M_WR | M_ARINR, 2'b00);
                pushStep(M_PCLD, 2'b00);
            end
            default: begin
                pushStep(M_RD | M_DRLD, 2'b00);
                pushStep(M_DRINR, 2'b00);
                pushStep(M_WR | (drZ ? M_PCINR : 12'h000), 2'b00);
            end
        endcase
        return 1'b0;
    endfunction

    task automatic checkHalted(input string tag);
        checkOutput({tag, ".run"}, 32'(bus.run_o), 32'd0);
        checkOutput({tag, ".t"}, 32'(bus.t_o), 32'd0);
        checkOutput({tag, ".strobes"}, 32'(getStrobes()), 32'd0);
        checkOutput({tag, ".acOp"}, 32'(bus.acOp_o), 32'd0);
    endtask

    task automatic startRun();
        bus.start_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        checkOutput("startRun.run", 32'(bus.run_o), 32'd1);
        checkOutput("startRun.t", 32'(bus.t_o), 32'd0);
    endtask

    // Called at the falling edge of a T0 cycle; returns at the falling edge after the instruction.
    task automatic applyStimulus(input logic [15:0] ir, input bit drZ, input int abortAt, output bit halted);
        logic [11:0] s;
        halted       = buildTrace(ir, drZ);
        bus.ir_i     = ir;
        bus.drZero_i = drZ;
        for (int k = 0; k < trace.size(); k++) begin
            if (k > 0) @(negedge clk);
            bus.start_i = 1'($urandom_range(0, 1));
            s = getStrobes();
            checkOutput($sformatf("ir%04h.T%0d.t", ir, k), 32'(bus.t_o), 32'(trace[k].t));
            checkOutput($sformatf("ir%04h.T%0d.strobes", ir, k), 32'(s), 32'(trace[k].strb));
            checkOutput($sformatf("ir%04h.T%0d.acOp", ir, k), 32'(bus.acOp_o), 32'(trace[k].acOp));
            checkOutput($sformatf("ir%04h.T%0d.run", ir, k), 32'(bus.run_o), 32'd1);
            checkOutput($sformatf("ir%04h.T%0d.rdWrExcl", ir, k), 32'(s[0] & s[1]), 32'd0);
            checkOutput($sformatf("ir%04h.T%0d.arOneHot", ir, k),
                        32'((32'(s[2]) + 32'(s[3]) + 32'(s[4]) + 32'(s[5])) <= 1), 32'd1);
            if (k == 3) begin
                checkOutput($sformatf("ir%04h.D", ir), 32'(bus.d_o), 32'(8'd1 << ir[14:12]));
                checkOutput($sformatf("ir%04h.I", ir), 32'(bus.i_o), 32'(ir[15]));
            end
            if (k == abortAt) return;
        end
        @(negedge clk);
        bus.start_i = 1'b0;
    endtask

    task automatic runAndRecover(input logic [15:0] ir, input bit drZ);
        bit halted;
        applyStimulus(ir, drZ, -1, halted);
        if (halted) begin
            checkHalted("afterHlt1");
            @(negedge clk);
            checkHalted("afterHlt2");
            startRun();
        end else begin
            checkOutput("nextT0.t", 32'(bus.t_o), 32'd0);
        end
    endtask

    initial begin
        bit          dummy;
        logic [15:0] ir;
        rst          = 1'b1;
        bus.start_i  = 1'b0;
        bus.ir_i     = '0;
        bus.drZero_i = 1'b0;
        repeat (2) @(negedge clk);
        checkHalted("reset");
        checkOutput("reset.D", 32'(bus.d_o), 32'd0);
        checkOutput("reset.I", 32'(bus.i_o), 32'd0);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checkHalted("idle");
        end
        startRun();

        runAndRecover(16'h2005, 1'b0);
        runAndRecover(16'hB005, 1'b0);
        runAndRecover(16'h6010, 1'b1);
        runAndRecover(16'h6010, 1'b0);
        runAndRecover(16'h7001, 1'b0);
        runAndRecover(16'hF001, 1'b0);

        for (int n = 0; n < 60; n++) begin
            ir = 16'($urandom);
            runAndRecover(ir, 1'($urandom_range(0, 1)));
        end

        // Abort a BSA in T4 while its write strobe is active.
        applyStimulus(16'h5020, 1'b0, 4, dummy);
        rst = 1'b1;
        bus.start_i = 1'b0;
        #1;
        checkHalted("rstMidBsa");
        checkOutput("rstMidBsa.memWr", 32'(bus.memWr_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checkHalted("postRstIdle");
        end
        startRun();
        runAndRecover(16'h2005, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
